// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit: forwarding select
// encodings, the scoreboard entry layout and the load opcode.
package hazard_pkg;

    localparam int SB_AW = 5;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_EALU = 2'b01;
    localparam logic [1:0] FWD_MALU = 2'b10;
    localparam logic [1:0] FWD_MDM  = 2'b11;

    localparam logic [5:0] OP_LW = 6'b100011;

    typedef struct packed {
        logic             valid;
        logic             wreg;
        logic             m2reg;
        logic [SB_AW-1:0] dest;
    } sb_entry_t;

    function automatic logic is_load_op(input logic [5:0] opcode);
        return opcode == OP_LW;
    endfunction

    // Youngest producer wins: EXE ALU results first, then whatever MEM holds.
    // A load still in EXE cannot forward; the stall logic covers that case.
    function automatic logic [1:0] fwd_sel(input sb_entry_t        e,
                                           input sb_entry_t        m,
                                           input logic             rd,
                                           input logic [SB_AW-1:0] src);
        logic [1:0] sel;
        sel = FWD_REG;
        if (rd && src != '0) begin
            if (e.valid && e.wreg && !e.m2reg && e.dest == src)
                sel = FWD_EALU;
            else if (m.valid && m.wreg && m.dest == src)
                sel = m.m2reg ? FWD_MDM : FWD_MALU;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_sb_stage.sv
// One scoreboard entry shadowing the destination of the instruction in a
// single pipeline stage; clear overrides load, otherwise the entry holds.
module hazard_sb_stage
    import hazard_pkg::*;
(
    input  logic      clock,
    input  logic      clrn,
    input  logic      load,
    input  logic      clear,
    input  sb_entry_t d,
    output sb_entry_t q
);

    // NOTE: state registers use non-blocking assignments so every entry
    // samples its neighbour's pre-edge value and the shift is order-free.
    always_ff @(posedge clock) begin
        if (!clrn)
            q <= '0;
        else if (clear)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Load-use stall, pipeline hold and ALU operand forwarding control for the
// 5-stage pipeline, plus a saturating count of load-use stall cycles.
module pipeline_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = SB_AW,
    parameter int STALL_CW = 16
) (
    input  logic                clock,
    input  logic                clrn,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                id_wreg,
    input  logic                id_m2reg,
    input  logic [REG_AW-1:0]   id_dest,
    input  logic                freeze,
    output logic                wpcir,
    output logic                bubble,
    output logic [1:0]          fwda,
    output logic [1:0]          fwdb,
    output logic [STALL_CW-1:0] stall_cnt
);

    sb_entry_t sb_e, sb_m, sb_w, e_next;
    logic      e_load_pending;
    logic      id_hits_e;
    logic      load_use;
    logic      advance;
    logic      unused_w;

    assign e_next = '{valid: id_valid,
                      wreg:  id_wreg & id_valid,
                      m2reg: id_m2reg,
                      dest:  id_dest};

    assign e_load_pending = sb_e.valid && sb_e.wreg && sb_e.m2reg && sb_e.dest != '0;
    assign id_hits_e      = (id_use_rs && id_rs == sb_e.dest) ||
                            (id_use_rt && id_rt == sb_e.dest);

    // A freeze holds everything, so the hazard is simply re-evaluated once it drops.
    assign load_use = !freeze && id_valid && e_load_pending && id_hits_e;
    assign advance  = !freeze;

    assign wpcir  = !freeze && !load_use;
    assign bubble = load_use;
    assign fwda   = fwd_sel(sb_e, sb_m, id_valid & id_use_rs, id_rs);
    assign fwdb   = fwd_sel(sb_e, sb_m, id_valid & id_use_rt, id_rt);

    hazard_sb_stage u_sb_e (
        .clock (clock),
        .clrn  (clrn),
        .load  (advance),
        .clear (load_use),
        .d     (e_next),
        .q     (sb_e)
    );

    hazard_sb_stage u_sb_m (
        .clock (clock),
        .clrn  (clrn),
        .load  (advance),
        .clear (1'b0),
        .d     (sb_e),
        .q     (sb_m)
    );

    // W is tracked for completeness only: the regfile write-then-read covers it.
    hazard_sb_stage u_sb_w (
        .clock (clock),
        .clrn  (clrn),
        .load  (advance),
        .clear (1'b0),
        .d     (sb_m),
        .q     (sb_w)
    );

    assign unused_w = ^sb_w;

    always_ff @(posedge clock) begin
        if (!clrn)
            stall_cnt <= '0;
        else if (load_use && stall_cnt != {STALL_CW{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: an in-flight instruction queue
// model checked every cycle, plus literal expectations at key points.
module tb_pipeline_hazard_unit;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clock;
    logic          clrn;
    logic          id_valid;
    logic [4:0]    id_rs, id_rt, id_dest;
    logic          id_use_rs, id_use_rt, id_wreg, id_m2reg;
    logic          freeze;
    logic          wpcir, bubble;
    logic [1:0]    fwda, fwdb;
    logic [CW-1:0] stall_cnt;

    int n_total = 0;
    int n_pass  = 0;

    // Narrow counter so saturation is reachable in a short run.
    pipeline_hazard_unit #(.REG_AW(5), .STALL_CW(CW)) dut (
        .clock     (clock),
        .clrn      (clrn),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_wreg   (id_wreg),
        .id_m2reg  (id_m2reg),
        .id_dest   (id_dest),
        .freeze    (freeze),
        .wpcir     (wpcir),
        .bubble    (bubble),
        .fwda      (fwda),
        .fwdb      (fwdb),
        .stall_cnt (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- model: instructions in flight, youngest first ----------
    typedef struct {
        bit       valid;
        bit       wreg;
        bit       load;
        bit [4:0] dest;
    } ins_t;

    ins_t in_flight[$];
    int   model_cnt = 0;
    bit   model_ok  = 0;

    function automatic ins_t empty_ins();
        ins_t x;
        x.valid = 0; x.wreg = 0; x.load = 0; x.dest = '0;
        return x;
    endfunction

    function automatic bit writes(input ins_t x, input bit [4:0] r);
        return x.valid && x.wreg && x.dest == r && r != 0;
    endfunction

    function automatic bit model_stall();
        ins_t e;
        e = in_flight[0];
        if (freeze || !id_valid || !e.load) return 0;
        return (id_use_rs && writes(e, id_rs)) || (id_use_rt && writes(e, id_rt));
    endfunction

    function automatic logic [1:0] model_fwd(input bit used, input bit [4:0] src);
        if (!id_valid || !used || src == 0) return 2'b00;
        if (writes(in_flight[0], src) && !in_flight[0].load) return 2'b01;
        if (writes(in_flight[1], src)) return in_flight[1].load ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clock) begin
        if (!clrn) begin
            in_flight = '{empty_ins(), empty_ins(), empty_ins()};
            model_cnt = 0;
            model_ok  = 1;
        end else if (model_ok && !freeze) begin
            ins_t nx;
            bit   st;
            st = model_stall();
            nx = empty_ins();
            if (!st) begin
                nx.valid = id_valid;
                nx.wreg  = id_wreg && id_valid;
                nx.load  = id_m2reg;
                nx.dest  = id_dest;
            end
            void'(in_flight.pop_back());
            in_flight.push_front(nx);
            if (st && model_cnt < CNT_MAX) model_cnt++;
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            bit st;
            st = model_stall();
            check("wpcir",     16'(wpcir),     16'(!freeze && !st));
            check("bubble",    16'(bubble),    16'(st));
            check("fwda",      16'(fwda),      16'(model_fwd(id_use_rs, id_rs)));
            check("fwdb",      16'(fwdb),      16'(model_fwd(id_use_rt, id_rt)));
            check("stall_cnt", 16'(stall_cnt), 16'(model_cnt));
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic wr,
                          input logic m2r, input logic [4:0] dest);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wreg = wr; id_m2reg = m2r; id_dest = dest;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lw(input logic [4:0] dest, input logic [4:0] base);
        set_id(1, base, dest, 1, 0, 1, 1, dest);
    endtask

    task automatic alu(input logic [4:0] dest, input logic [4:0] rs, input logic [4:0] rt);
        set_id(1, rs, rt, 1, 1, 1, 0, dest);
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
        check(name, act, exp);
    endtask

    // ---------------- directed sequence -------------------------------------
    initial begin
        clrn = 1'b0; freeze = 1'b0; nop();
        repeat (2) advance();
        settle();
        lit("rst_wpcir", 16'(wpcir), 16'd1);
        lit("rst_bubble", 16'(bubble), 16'd0);
        lit("rst_fwda", 16'(fwda), 16'd0);
        lit("rst_fwdb", 16'(fwdb), 16'd0);
        lit("rst_cnt", 16'(stall_cnt), 16'd0);
        advance();
        clrn = 1'b1;
        advance();

        // lw $2,0($1); add $3,$2,$4
        lw(2, 1); advance();
        alu(3, 2, 4); settle();
        lit("lu_wpcir", 16'(wpcir), 16'd0);
        lit("lu_bubble", 16'(bubble), 16'd1);
        advance(); settle();
        lit("lu_fwda_mdm", 16'(fwda), 16'd3);
        lit("lu_wpcir_after", 16'(wpcir), 16'd1);
        lit("lu_cnt", 16'(stall_cnt), 16'd1);
        advance();
        nop(); repeat (3) advance();

        // ALU to ALU: adjacent, then one NOP apart
        alu(5, 1, 1); advance();
        alu(6, 5, 5); settle();
        lit("ealu_fwda", 16'(fwda), 16'd1);
        lit("ealu_fwdb", 16'(fwdb), 16'd1);
        lit("ealu_bubble", 16'(bubble), 16'd0);
        advance(); nop(); repeat (3) advance();
        alu(5, 1, 1); advance();
        nop(); advance();
        alu(6, 5, 1); settle();
        lit("malu_fwda", 16'(fwda), 16'd2);
        lit("malu_fwdb", 16'(fwdb), 16'd0);
        advance(); nop(); repeat (3) advance();

        // E priority over M, then register 0
        alu(7, 1, 1); advance();
        alu(7, 2, 2); advance();
        alu(8, 7, 3); settle();
        lit("eprio_fwda", 16'(fwda), 16'd1);
        advance(); nop(); repeat (3) advance();
        alu(0, 1, 1); advance();
        alu(9, 0, 0); settle();
        lit("r0_fwda", 16'(fwda), 16'd0);
        lit("r0_fwdb", 16'(fwdb), 16'd0);
        advance();
        lw(0, 1); advance();
        alu(9, 0, 0); settle();
        lit("r0_nostall", 16'(bubble), 16'd0);
        advance(); nop(); repeat (3) advance();

        // invalid ID slot behind a load
        lw(2, 1); advance();
        set_id(0, 2, 2, 1, 1, 1, 0, 3); settle();
        lit("inv_bubble", 16'(bubble), 16'd0);
        lit("inv_fwda", 16'(fwda), 16'd0);
        advance(); nop(); repeat (3) advance();

        // freeze across a load-use hazard
        lw(2, 1); advance();
        alu(3, 2, 4); freeze = 1'b1;
        repeat (3) begin
            settle();
            lit("frz_wpcir", 16'(wpcir), 16'd0);
            lit("frz_bubble", 16'(bubble), 16'd0);
            lit("frz_cnt", 16'(stall_cnt), 16'd1);
            advance();
        end
        freeze = 1'b0; settle();
        lit("frz_rel_bubble", 16'(bubble), 16'd1);
        advance(); settle();
        lit("frz_rel_cnt", 16'(stall_cnt), 16'd2);
        lit("frz_rel_fwda", 16'(fwda), 16'd3);
        advance(); nop(); repeat (3) advance();

        // saturate the stall counter with a repeating self-dependent load
        lw(2, 2); repeat (40) advance();
        nop(); advance(); settle();
        lit("sat_cnt", 16'(stall_cnt), 16'(CNT_MAX));
        advance();
        lw(2, 1); advance();
        alu(3, 2, 4); settle();
        lit("sat_bubble", 16'(bubble), 16'd1);
        advance(); settle();
        lit("sat_hold", 16'(stall_cnt), 16'(CNT_MAX));
        advance(); nop(); repeat (3) advance();

        // reset in the middle of a stall
        lw(2, 1); advance();
        alu(3, 2, 4); clrn = 1'b0; settle();
        lit("rstst_bubble", 16'(bubble), 16'd1);
        advance();
        clrn = 1'b1; settle();
        lit("rstst_wpcir", 16'(wpcir), 16'd1);
        lit("rstst_bubble0", 16'(bubble), 16'd0);
        lit("rstst_cnt", 16'(stall_cnt), 16'd0);
        lit("rstst_fwda", 16'(fwda), 16'd0);
        advance(); nop(); repeat (3) advance();

        // reset in the middle of a freeze
        lw(2, 1); advance();
        alu(3, 2, 4); freeze = 1'b1; advance();
        clrn = 1'b0; advance();
        clrn = 1'b1; freeze = 1'b0; settle();
        lit("rstfz_bubble", 16'(bubble), 16'd0);
        lit("rstfz_wpcir", 16'(wpcir), 16'd1);
        advance(); nop(); repeat (2) advance();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
